// File: rtl/ocl_regfile_pkg.sv
// Shared types and helpers for the OCL AXI4-Lite register file.
package ocl_regfile_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_e;

    typedef enum logic {
        WR_IDLE,
        WR_RESP
    } wr_state_e;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ADDR,
        RD_RESP
    } rd_state_e;

    localparam logic [31:0] UNIMPL_VAL = 32'hDEAD_BEEF;

    function automatic logic [31:0] bswap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/ocl_reg_decode.sv
// Byte address to register index decode; a miss covers unaligned and out-of-window addresses.
module ocl_reg_decode #(
    parameter int                NUM_REGS  = 8,
    parameter int                ADDR_W    = 32,
    parameter int                IDX_W     = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0500
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx
);

    logic [ADDR_W-1:0] off;

    // Addresses below BASE_ADDR wrap to large offsets and fall out of the window.
    assign off = addr - BASE_ADDR;
    assign hit = (addr[1:0] == 2'b00) && (off < ADDR_W'(NUM_REGS * 4));
    assign idx = off[IDX_W+1:2];

endmodule

// File: rtl/ocl_axil_regfile.sv
// AXI4-Lite CSR block on the OCL path: byte-strobe writes, RO/byte-swap read masks, SLVERR on misses.
// state   | meaning
// WR_IDLE | collecting AW and W in independent holds
// WR_RESP | bvalid asserted, waiting for bready
// RD_IDLE | arready asserted
// RD_ADDR | address held, data captured on next edge
// RD_RESP | rvalid asserted, waiting for rready
module ocl_axil_regfile
    import ocl_regfile_pkg::*;
#(
    parameter int                       NUM_REGS  = 8,
    parameter int                       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]        BASE_ADDR = 32'h0000_0500,
    parameter logic [NUM_REGS-1:0]      RO_MASK   = '0,
    parameter logic [NUM_REGS-1:0]      SWAP_MASK = '0,
    parameter logic [NUM_REGS*32-1:0]   RESET_VAL = '0
) (
    input  logic                     clk_main_a0,
    input  logic                     rst_main_n,
    input  logic                     s_awvalid,
    output logic                     s_awready,
    input  logic [ADDR_W-1:0]        s_awaddr,
    input  logic                     s_wvalid,
    output logic                     s_wready,
    input  logic [31:0]              s_wdata,
    input  logic [3:0]               s_wstrb,
    output logic                     s_bvalid,
    input  logic                     s_bready,
    output logic [1:0]               s_bresp,
    input  logic                     s_arvalid,
    output logic                     s_arready,
    input  logic [ADDR_W-1:0]        s_araddr,
    output logic                     s_rvalid,
    input  logic                     s_rready,
    output logic [31:0]              s_rdata,
    output logic [1:0]               s_rresp,
    input  logic [NUM_REGS*32-1:0]   ro_value_i,
    output logic [NUM_REGS*32-1:0]   reg_q,
    output logic [NUM_REGS-1:0]      reg_wr_pulse
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [1:0]  rst_sync_q;
    logic        rst_n;
    wr_state_e   wr_state_q, wr_state_d;
    rd_state_e   rd_state_q, rd_state_d;
    logic        aw_held_q, w_held_q;
    logic [ADDR_W-1:0] aw_addr_q, ar_addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    resp_e       bresp_q, rresp_q;
    logic [31:0] rdata_q, rd_word;
    logic        wr_hit, rd_hit, wr_ok, wr_commit;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic [31:0] regs   [NUM_REGS];
    logic [31:0] ro_arr [NUM_REGS];

    // Assertion propagates asynchronously through the synchroniser; release takes two edges.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) rst_sync_q <= 2'b00;
        else             rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    ocl_reg_decode #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .IDX_W(IDX_W), .BASE_ADDR(BASE_ADDR))
        u_wr_decode (.addr(aw_addr_q), .hit(wr_hit), .idx(wr_idx));
    ocl_reg_decode #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .IDX_W(IDX_W), .BASE_ADDR(BASE_ADDR))
        u_rd_decode (.addr(ar_addr_q), .hit(rd_hit), .idx(rd_idx));

    assign s_bvalid  = (wr_state_q == WR_RESP);
    assign s_awready = rst_n && !aw_held_q && !s_bvalid;
    assign s_wready  = rst_n && !w_held_q && !s_bvalid;
    assign s_bresp   = bresp_q;
    assign wr_commit = aw_held_q && w_held_q;
    assign wr_ok     = wr_hit && !RO_MASK[wr_idx];

    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            WR_IDLE: if (wr_commit) wr_state_d = WR_RESP;
            WR_RESP: if (s_bready)  wr_state_d = WR_IDLE;
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk_main_a0 or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= WR_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_addr_q  <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            if (s_awvalid && s_awready) begin
                aw_held_q <= 1'b1;
                aw_addr_q <= s_awaddr;
            end else if (wr_commit) begin
                aw_held_q <= 1'b0;
            end
            if (s_wvalid && s_wready) begin
                w_held_q <= 1'b1;
                wdata_q  <= s_wdata;
                wstrb_q  <= s_wstrb;
            end else if (wr_commit) begin
                w_held_q <= 1'b0;
            end
            if (wr_commit)                  bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            else if (s_bvalid && s_bready)  bresp_q <= RESP_OKAY;
        end
    end

    assign s_arready = rst_n && (rd_state_q == RD_IDLE);
    assign s_rvalid  = (rd_state_q == RD_RESP);
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            RD_IDLE: if (s_arvalid) rd_state_d = RD_ADDR;
            RD_ADDR: rd_state_d = RD_RESP;
            RD_RESP: if (s_rready)  rd_state_d = RD_IDLE;
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        rd_word = RO_MASK[rd_idx] ? ro_arr[rd_idx] : regs[rd_idx];
        if (SWAP_MASK[rd_idx]) rd_word = bswap32(rd_word);
    end

    // Capture samples regs before any same-edge write lands, so reads see the old value.
    always_ff @(posedge clk_main_a0 or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= RD_IDLE;
            ar_addr_q  <= '0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            if (s_arvalid && s_arready) ar_addr_q <= s_araddr;
            if (rd_state_q == RD_ADDR) begin
                rdata_q <= rd_hit ? rd_word : UNIMPL_VAL;
                rresp_q <= rd_hit ? RESP_OKAY : RESP_SLVERR;
            end else if (s_rvalid && s_rready) begin
                rdata_q <= '0;
                rresp_q <= RESP_OKAY;
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        logic [31:0] reg_r;
        logic        pulse_r;
        logic        sel;

        assign sel = wr_commit && wr_ok && (wr_idx == IDX_W'(i));

        always_ff @(posedge clk_main_a0 or negedge rst_n) begin
            if (!rst_n) begin
                reg_r   <= RESET_VAL[i*32 +: 32];
                pulse_r <= 1'b0;
            end else begin
                pulse_r <= sel;
                for (int b = 0; b < 4; b++) begin
                    if (sel && wstrb_q[b]) reg_r[b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
        end

        assign regs[i]              = reg_r;
        assign ro_arr[i]            = ro_value_i[i*32 +: 32];
        assign reg_q[i*32 +: 32]    = reg_r;
        assign reg_wr_pulse[i]      = pulse_r;
    end

endmodule

// File: tb/tb_ocl_axil_regfile.sv
// Randomised self-checking bench for ocl_axil_regfile against a word-array reference model.
module tb_ocl_axil_regfile;

    localparam int          NR   = 8;
    localparam logic [31:0] BASE = 32'h0000_0500;
    localparam logic [7:0]  RO   = 8'h80;
    localparam logic [7:0]  SW   = 8'h01;
    localparam logic [NR*32-1:0] RST_IMG = {
        32'hC0DE_0007, 32'hC0DE_0006, 32'hC0DE_0005, 32'hC0DE_0004,
        32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};

    logic clk_main_a0 = 1'b0;
    logic rst_main_n  = 1'b0;
    logic s_awvalid = 0, s_wvalid = 0, s_bready = 0, s_arvalid = 0, s_rready = 0;
    logic s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [31:0] s_awaddr = 0, s_araddr = 0, s_wdata = 0, s_rdata;
    logic [3:0]  s_wstrb = 0;
    logic [1:0]  s_bresp, s_rresp;
    logic [NR*32-1:0] ro_value_i = '0;
    logic [NR*32-1:0] reg_q;
    logic [NR-1:0]    reg_wr_pulse;

    int checks = 0;
    int passes = 0;
    logic [31:0] exp_mem [NR];
    int pulse_tot [NR];

    always #5 clk_main_a0 = ~clk_main_a0;

    ocl_axil_regfile #(
        .NUM_REGS(NR), .ADDR_W(32), .BASE_ADDR(BASE),
        .RO_MASK(RO), .SWAP_MASK(SW), .RESET_VAL(RST_IMG)
    ) dut (
        .clk_main_a0(clk_main_a0), .rst_main_n(rst_main_n),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .ro_value_i(ro_value_i), .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
    );

    always @(posedge clk_main_a0) begin
        for (int i = 0; i < NR; i++) if (reg_wr_pulse[i] === 1'b1) pulse_tot[i]++;
    end

    // ---------------- reference model ----------------
    function automatic bit model_hit(input logic [31:0] a, output int idx);
        logic [31:0] off;
        off = a - BASE;
        idx = int'(off / 4);
        return (a % 4 == 0) && (off < NR * 4);
    endfunction

    function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d,
                                               input logic [3:0] s);
        int idx;
        if (!model_hit(a, idx) || RO[idx]) return 2'b10;
        for (int b = 0; b < 4; b++) if (s[b]) exp_mem[idx][b*8 +: 8] = d[b*8 +: 8];
        return 2'b00;
    endfunction

    function automatic logic [1:0] model_read(input logic [31:0] a, output logic [31:0] d);
        int idx;
        logic [31:0] w;
        if (!model_hit(a, idx)) begin
            d = 32'hDEAD_BEEF;
            return 2'b10;
        end
        w = RO[idx] ? ro_value_i[idx*32 +: 32] : exp_mem[idx];
        d = SW[idx] ? {w[7:0], w[15:8], w[23:16], w[31:24]} : w;
        return 2'b00;
    endfunction

    function automatic logic [NR*32-1:0] model_image();
        logic [NR*32-1:0] img;
        for (int i = 0; i < NR; i++) img[i*32 +: 32] = exp_mem[i];
        return img;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) exp_mem[i] = RST_IMG[i*32 +: 32];
    endfunction

    // ---------------- bus drivers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_main_a0);
            #1;
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int awd, input int wd, output logic [1:0] resp, output int lat);
        int cyc;
        bit aw_done, w_done, aw_fire, w_fire;
        cyc = 0; aw_done = 0; w_done = 0;
        while (!(aw_done && w_done) && cyc < 50) begin
            s_awaddr  = a;
            s_awvalid = !aw_done && (cyc >= awd);
            s_wdata   = d;
            s_wstrb   = s;
            s_wvalid  = !w_done && (cyc >= wd);
            aw_fire   = s_awvalid && s_awready;
            w_fire    = s_wvalid && s_wready;
            tick(1);
            if (aw_fire) aw_done = 1;
            if (w_fire)  w_done = 1;
            cyc++;
        end
        s_awvalid = 0;
        s_wvalid  = 0;
        lat = 0;
        while (!s_bvalid && lat < 20) begin
            tick(1);
            lat++;
        end
        resp = s_bresp;
        if (s_bvalid) begin
            s_bready = 1;
            tick(1);
            s_bready = 0;
        end
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                            output int lat);
        int cyc;
        cyc = 0;
        s_araddr  = a;
        s_arvalid = 1;
        while (!s_arready && cyc < 20) begin
            tick(1);
            cyc++;
        end
        tick(1);
        s_arvalid = 0;
        lat = 0;
        while (!s_rvalid && lat < 20) begin
            tick(1);
            lat++;
        end
        d    = s_rdata;
        resp = s_rresp;
        if (s_rvalid) begin
            s_rready = 1;
            tick(1);
            s_rready = 0;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        tick(3);
        checks++;
        if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 5'b0 || reg_wr_pulse !== '0)
            $display("FAIL reset_ctrl: got rdy/valid %b pulse %h required 0", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid}, reg_wr_pulse);
        else passes++;
        checks++;
        if (reg_q !== RST_IMG || s_rdata !== 32'h0 || s_bresp !== 2'b00 || s_rresp !== 2'b00)
            $display("FAIL reset_data: got reg_q %h rdata %h required reg_q %h rdata 0", reg_q, s_rdata, RST_IMG);
        else passes++;
        rst_main_n = 1;
        tick(1);
        checks++;
        if (s_awready !== 1'b0) $display("FAIL reset_sync_1: got awready %b required 0", s_awready);
        else passes++;
        tick(1);
        checks++;
        if ({s_awready, s_wready, s_arready} !== 3'b111)
            $display("FAIL reset_sync_2: got ready %b required 111", {s_awready, s_wready, s_arready});
        else passes++;
    endtask

    task automatic test_w_before_aw();
        logic [1:0] r, er;
        logic [31:0] d, ed;
        int lat;
        axi_write(BASE, 32'h1234_5678, 4'hF, 3, 0, r, lat);
        er = model_write(BASE, 32'h1234_5678, 4'hF);
        checks++;
        if (r !== er || lat != 1) $display("FAIL w_before_aw_resp: got resp %b lat %0d required %b lat 1", r, lat, er);
        else passes++;
        checks++;
        if (reg_q[31:0] !== 32'h1234_5678) $display("FAIL w_before_aw_reg0: got %h required 12345678", reg_q[31:0]);
        else passes++;
        axi_read(BASE, d, r, lat);
        er = model_read(BASE, ed);
        checks++;
        if (d !== 32'h7856_3412 || d !== ed || r !== er || lat != 1)
            $display("FAIL swap_read: got %h resp %b lat %0d required %h resp %b lat 1", d, r, lat, ed, er);
        else passes++;
    endtask

    task automatic test_strobes();
        logic [1:0] r;
        int lat, p1, pall;
        axi_write(BASE + 4, 32'hAABB_CCDD, 4'hF, 0, 0, r, lat);
        void'(model_write(BASE + 4, 32'hAABB_CCDD, 4'hF));
        p1 = pulse_tot[1];
        pall = 0;
        for (int i = 0; i < NR; i++) pall += pulse_tot[i];
        axi_write(BASE + 4, 32'h1122_3344, 4'b0101, 1, 0, r, lat);
        void'(model_write(BASE + 4, 32'h1122_3344, 4'b0101));
        for (int i = 0; i < NR; i++) pall -= pulse_tot[i];
        checks++;
        if (reg_q[63:32] !== 32'hAA22_CC44 || r !== 2'b00)
            $display("FAIL strobe_merge: got %h resp %b required aa22cc44 resp 00", reg_q[63:32], r);
        else passes++;
        checks++;
        if (pulse_tot[1] - p1 != 1 || pall != -1)
            $display("FAIL strobe_pulse: got reg1 pulse cycles %0d total %0d required 1", pulse_tot[1] - p1, -pall);
        else passes++;
    endtask

    task automatic test_errors();
        logic [1:0] r, er;
        logic [31:0] d, ed;
        logic [31:0] addrs [3];
        int lat, p7;
        p7 = pulse_tot[7];
        axi_write(BASE + 32'h1C, $urandom, 4'hF, 0, 0, r, lat);
        checks++;
        if (r !== 2'b10 || reg_q[255:224] !== exp_mem[7] || pulse_tot[7] != p7)
            $display("FAIL ro_write: got resp %b reg7 %h pulses %0d required 10 %h 0", r, reg_q[255:224], pulse_tot[7] - p7, exp_mem[7]);
        else passes++;
        axi_write(BASE - 4, $urandom, 4'hF, 0, 0, r, lat);
        checks++;
        if (r !== 2'b10 || reg_q !== model_image())
            $display("FAIL below_base_write: got resp %b required 10", r);
        else passes++;
        addrs[0] = BASE + 32'h20; addrs[1] = BASE + 2; addrs[2] = BASE + 32'h1C;
        foreach (addrs[k]) begin
            axi_read(addrs[k], d, r, lat);
            er = model_read(addrs[k], ed);
            checks++;
            if (d !== ed || r !== er)
                $display("FAIL err_read_%0h: got %h resp %b required %h resp %b", addrs[k], d, r, ed, er);
            else passes++;
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] r, er, b0;
        logic [31:0] d, ed, r0, wd;
        int cyc, lat;
        wd = $urandom;
        er = model_read(BASE + 8, ed);
        s_awaddr = BASE + 4; s_wdata = wd; s_wstrb = 4'hF; s_araddr = BASE + 8;
        s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
        tick(1);
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
        cyc = 0;
        while (!(s_bvalid && s_rvalid) && cyc < 20) begin
            tick(1);
            cyc++;
        end
        b0 = s_bresp;
        r0 = s_rdata;
        checks++;
        if (b0 !== model_write(BASE + 4, wd, 4'hF) || r0 !== ed || s_rresp !== er || cyc != 1)
            $display("FAIL bp_first: got bresp %b rdata %h cyc %0d required 00 %h 1", b0, r0, cyc, ed);
        else passes++;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checks++;
            if ({s_awready, s_wready, s_arready} !== 3'b000 || !s_bvalid || !s_rvalid ||
                s_bresp !== b0 || s_rdata !== r0)
                $display("FAIL bp_stall_%0d: got ready %b bresp %b rdata %h required 000 %b %h", i, {s_awready, s_wready, s_arready}, s_bresp, s_rdata, b0, r0);
            else passes++;
        end
        s_bready = 1; s_rready = 1;
        tick(1);
        s_bready = 0; s_rready = 0;
        checks++;
        if (s_bvalid || s_rvalid || s_rdata !== 32'h0)
            $display("FAIL bp_release: got bvalid %b rvalid %b rdata %h required 0 0 0", s_bvalid, s_rvalid, s_rdata);
        else passes++;
        axi_write(BASE + 12, 32'h0BAD_F00D, 4'hF, 0, 0, r, lat);
        er = model_write(BASE + 12, 32'h0BAD_F00D, 4'hF);
        axi_read(BASE + 4, d, r, lat);
        er = model_read(BASE + 4, ed);
        checks++;
        if (d !== ed || r !== er || reg_q !== model_image())
            $display("FAIL bp_after: got %h required %h", d, ed);
        else passes++;
    endtask

    task automatic test_same_edge();
        logic [1:0] r;
        logic [31:0] d, ed_old, ed_new;
        int cyc, lat;
        axi_write(BASE + 8, 32'h0, 4'hF, 0, 0, r, lat);
        void'(model_write(BASE + 8, 32'h0, 4'hF));
        void'(model_read(BASE + 8, ed_old));
        s_awaddr = BASE + 8; s_wdata = 32'h5; s_wstrb = 4'hF; s_araddr = BASE + 8;
        s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
        tick(1);
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
        cyc = 0;
        while (!(s_bvalid && s_rvalid) && cyc < 20) begin
            tick(1);
            cyc++;
        end
        void'(model_write(BASE + 8, 32'h5, 4'hF));
        checks++;
        if (s_rdata !== ed_old || !s_rvalid) $display("FAIL same_edge_old: got %h required %h", s_rdata, ed_old);
        else passes++;
        s_bready = 1; s_rready = 1;
        tick(1);
        s_bready = 0; s_rready = 0;
        axi_read(BASE + 8, d, r, lat);
        void'(model_read(BASE + 8, ed_new));
        checks++;
        if (d !== ed_new || d !== 32'h5) $display("FAIL same_edge_new: got %h required %h", d, ed_new);
        else passes++;
    endtask

    task automatic test_random();
        logic [1:0] r, er;
        logic [31:0] a, d, ed, wd;
        logic [3:0] st;
        int lat, sel, idx, pbefore, pall;
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(9);
            if (sel < 8)       a = BASE + 4 * sel;
            else if (sel == 8) a = BASE + 32'h20 + 4 * $urandom_range(3);
            else               a = BASE + 4 * $urandom_range(7) + $urandom_range(3, 1);
            if ($urandom_range(1) == 0) begin
                wd = $urandom;
                st = 4'($urandom);
                pall = 0;
                for (int i = 0; i < NR; i++) pall += pulse_tot[i];
                pbefore = model_hit(a, idx) ? pulse_tot[idx] : 0;
                axi_write(a, wd, st, $urandom_range(2), $urandom_range(2), r, lat);
                er = model_write(a, wd, st);
                for (int i = 0; i < NR; i++) pall -= pulse_tot[i];
                checks++;
                if (r !== er || lat != 1 || reg_q !== model_image() || -pall != (er == 2'b00 ? 1 : 0) ||
                    (er == 2'b00 && pulse_tot[idx] - pbefore != 1))
                    $display("FAIL rand_wr_%0d: addr %h got resp %b lat %0d pulses %0d required resp %b lat 1 pulses %0d", n, a, r, lat, -pall, er, (er == 2'b00) ? 1 : 0);
                else passes++;
            end else begin
                axi_read(a, d, r, lat);
                er = model_read(a, ed);
                checks++;
                if (d !== ed || r !== er || lat != 1)
                    $display("FAIL rand_rd_%0d: addr %h got %h resp %b lat %0d required %h resp %b", n, a, d, r, lat, ed, er);
                else passes++;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] r;
        int cyc;
        s_awaddr = BASE; s_awvalid = 1;
        tick(1);
        s_awvalid = 0;
        tick(1);
        #2 rst_main_n = 0;
        #1;
        model_reset();
        checks++;
        if (s_bvalid || s_awready || reg_q !== RST_IMG)
            $display("FAIL mid_reset_async: got bvalid %b awready %b reg_q %h required 0 0 %h", s_bvalid, s_awready, reg_q, RST_IMG);
        else passes++;
        tick(2);
        rst_main_n = 1;
        tick(1);
        checks++;
        if (s_awready !== 1'b0) $display("FAIL mid_reset_sync1: got awready %b required 0", s_awready);
        else passes++;
        tick(1);
        checks++;
        if (s_awready !== 1'b1) $display("FAIL mid_reset_sync2: got awready %b required 1", s_awready);
        else passes++;
        s_wdata = 32'hFEED_0001; s_wstrb = 4'hF; s_wvalid = 1;
        tick(1);
        s_wvalid = 0;
        cyc = 0;
        for (int i = 0; i < 5; i++) begin
            if (s_bvalid) cyc++;
            tick(1);
        end
        checks++;
        if (cyc != 0 || reg_q !== RST_IMG)
            $display("FAIL mid_reset_dropped: got bvalid cycles %0d reg_q %h required 0 %h", cyc, reg_q, RST_IMG);
        else passes++;
        s_awaddr = BASE + 4; s_awvalid = 1;
        tick(1);
        s_awvalid = 0;
        cyc = 0;
        while (!s_bvalid && cyc < 20) begin
            tick(1);
            cyc++;
        end
        r = s_bresp;
        s_bready = 1;
        tick(1);
        s_bready = 0;
        void'(model_write(BASE + 4, 32'hFEED_0001, 4'hF));
        checks++;
        if (r !== 2'b00 || cyc != 1 || reg_q !== model_image())
            $display("FAIL mid_reset_recover: got resp %b cyc %0d reg1 %h required 00 1 %h", r, cyc, reg_q[63:32], exp_mem[1]);
        else passes++;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            pulse_tot[i] = 0;
            ro_value_i[i*32 +: 32] = $urandom;
        end
        model_reset();
        test_reset();
        test_w_before_aw();
        test_strobes();
        test_errors();
        test_backpressure();
        test_same_edge();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
